// File: rtl/mem_bus_defs.sv
// Shared bus definitions for the fetch/mem responder.
// Modes, channel ids, FSM states, request bundle, window helpers.
package mem_bus_defs;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic CH_FETCH = 1'b0;
  localparam logic CH_MEM   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // Byte address falls inside [base, base + 4*2**aw).
  function automatic logic win_hit(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned aw
  );
    return (addr >= base) &&
      ({32'd0, addr - base} < (64'd4 << aw));
  endfunction

  // Word offset of addr relative to base.
  function automatic logic [31:0] word_off(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/bram_1rw_be.sv
// Single-port 32b RAM, 4 byte enables, registered read.
// Ports: clk, en, we, wstrb, addr, wdata -> rdata (read-before-write).
module bram_1rw_be #(
  parameter int    ADDR_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Responder for core fetch/mem request-response buses onto one RAM.
// Ports: freq_*/mreq_* request strobes in, *_response_enable/data out, proto_err.
module bus_mem_responder
  import mem_bus_defs::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        proto_err
);

  state_t state, next_state;

  req_t f_in, m_in;
  req_t slot_f, slot_m;
  req_t sel_req, cur_req;

  logic [1:0] strb;
  logic [1:0] pend;
  logic [1:0] done;
  logic [1:0] free;
  logic [1:0] acc;
  logic [1:0] drop;
  logic [1:0] cand;

  logic gnt;
  logic last_grant;
  logic sel;
  logic do_grant;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;
  logic [31:0]           rd_word;

  assign f_in = {freq_mode, freq_addr,
                 freq_wdata, freq_wstrb};
  assign m_in = {mreq_mode, mreq_addr,
                 mreq_wdata, mreq_wstrb};
  assign strb = {mem_request_enable,
                 fetch_request_enable};

  // A slot is free when empty or when its
  // response goes out this very cycle.
  always_comb begin
    done = '0;
    if (state == ST_RESP) done[gnt] = 1'b1;
    free = ~pend | done;
    acc  = strb & free;
    drop = strb & ~free;
    cand = pend | acc;
  end

  always_comb begin
    if (cand == 2'b11) sel = ~last_grant;
    else if (cand[1])  sel = CH_MEM;
    else               sel = CH_FETCH;
  end

  assign do_grant = (state == ST_IDLE) && (|cand);

  // A same-cycle strobe is served straight
  // from the inputs, bypassing its slot.
  always_comb begin
    if (sel == CH_MEM)
      sel_req = pend[1] ? slot_m : m_in;
    else
      sel_req = pend[0] ? slot_f : f_in;
  end

  assign cur_req = (gnt == CH_MEM) ? slot_m : slot_f;

  assign ram_we = do_grant &&
    (sel_req.mode == MODE_WRITE) &&
    win_hit(sel_req.addr, BASE_ADDR, ADDR_WIDTH);

  assign ram_addr = ADDR_WIDTH'(
    word_off(sel_req.addr, BASE_ADDR));

  assign rd_word =
    ((cur_req.mode == MODE_READ) &&
     win_hit(cur_req.addr, BASE_ADDR, ADDR_WIDTH))
    ? ram_rdata : 32'h0;

  bram_1rw_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (do_grant),
    .we    (ram_we),
    .wstrb (sel_req.wstrb),
    .addr  (ram_addr),
    .wdata (sel_req.wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (do_grant) next_state = ST_ACCESS;
      ST_ACCESS: next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      pend       <= '0;
      slot_f     <= '0;
      slot_m     <= '0;
      gnt        <= CH_FETCH;
      last_grant <= CH_MEM;
      proto_err  <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      fresp_data <= 32'h0;
      mresp_data <= 32'h0;
    end else begin
      state <= next_state;
      pend  <= (pend & ~done) | acc;
      if (acc[0]) slot_f <= f_in;
      if (acc[1]) slot_m <= m_in;
      if (do_grant) begin
        gnt        <= sel;
        last_grant <= sel;
      end
      if (|drop) proto_err <= 1'b1;
      fetch_response_enable <=
        (state == ST_ACCESS) && (gnt == CH_FETCH);
      mem_response_enable <=
        (state == ST_ACCESS) && (gnt == CH_MEM);
      if ((state == ST_ACCESS) && (gnt == CH_FETCH))
        fresp_data <= rd_word;
      if ((state == ST_ACCESS) && (gnt == CH_MEM))
        mresp_data <= rd_word;
    end
  end

endmodule
